// File: rtl/alu_exec_ctrl.sv
// Execute-stage sequencer: latches one ALU op from the IFU, runs it down the
// single-cycle, multiplier, divider or memory path, then pulses finish once.
module alu_exec_ctrl #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_TIMEOUT = 80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  func_control,
  input  logic [3:0]  inner_control,
  input  logic        mem_enable,
  output logic [3:0]  func_q,
  output logic [3:0]  inner_q,
  input  logic [63:0] alu_result,
  output logic        csr_we_gate,
  output logic        div_start,
  input  logic        div_done,
  input  logic [63:0] div_result,
  output logic        mem_req,
  output logic [63:0] mem_addr,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        wb_valid,
  output logic [63:0] wb_data,
  output logic        alu_finish,
  output logic        div_timeout_err
);

  localparam int CntMax = (MUL_LATENCY > DIV_TIMEOUT) ? MUL_LATENCY : DIV_TIMEOUT;
  localparam int CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {IDLE, EXEC, WAIT_MUL, WAIT_DIV, WAIT_MEM, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      func_d, inner_d;
  logic            memEn_q, memEn_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [63:0]     wbData_q, wbData_d;
  logic [63:0]     memAddr_q, memAddr_d;
  logic            divErr_q, divErr_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      func_q    <= '0;
      inner_q   <= '0;
      memEn_q   <= 1'b0;
      cnt_q     <= '0;
      wbData_q  <= '0;
      memAddr_q <= '0;
      divErr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      func_q    <= func_d;
      inner_q   <= inner_d;
      memEn_q   <= memEn_d;
      cnt_q     <= cnt_d;
      wbData_q  <= wbData_d;
      memAddr_q <= memAddr_d;
      divErr_q  <= divErr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    func_d    = func_q;
    inner_d   = inner_q;
    memEn_d   = memEn_q;
    cnt_d     = cnt_q;
    wbData_d  = wbData_q;
    memAddr_d = memAddr_q;
    divErr_d  = divErr_q;
    case (state_q)
      IDLE: begin
        if (instr_valid) begin
          func_d  = func_control;
          inner_d = inner_control;
          memEn_d = mem_enable;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Memory access outranks every unit select, including div and csr.
        if (memEn_q) begin
          memAddr_d = alu_result;
          state_d   = WAIT_MEM;
        end else if (func_q == 4'd3) begin
          cnt_d   = '0;
          state_d = WAIT_DIV;
        end else if (func_q == 4'd5) begin
          if (MUL_LATENCY <= 1) begin
            wbData_d = alu_result;
            state_d  = DONE;
          end else begin
            cnt_d   = CntW'(MUL_LATENCY - 1);
            state_d = WAIT_MUL;
          end
        end else begin
          wbData_d = alu_result;
          state_d  = DONE;
        end
      end
      WAIT_MUL: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          wbData_d = alu_result;
          state_d  = DONE;
        end
      end
      WAIT_DIV: begin
        if (div_done) begin
          wbData_d = div_result;
          state_d  = DONE;
        end else if (cnt_q == CntW'(DIV_TIMEOUT - 1)) begin
          wbData_d = '1;
          divErr_d = 1'b1;
          state_d  = DONE;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      WAIT_MEM: begin
        if (mem_ack) begin
          wbData_d = mem_rdata;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The request is visible in EXEC already so ack latency counts from its first cycle.
  always_comb begin
    instr_ready     = (state_q == IDLE);
    div_start       = (state_q == EXEC) && !memEn_q && (func_q == 4'd3);
    csr_we_gate     = (state_q == EXEC) && !memEn_q && (func_q == 4'd8);
    mem_req         = ((state_q == EXEC) && memEn_q) || ((state_q == WAIT_MEM) && !mem_ack);
    mem_addr        = ((state_q == EXEC) && memEn_q) ? alu_result : memAddr_q;
    wb_valid        = (state_q == DONE);
    alu_finish      = (state_q == DONE);
    wb_data         = wbData_q;
    div_timeout_err = divErr_q;
  end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: vector table plus hand sequences, with completions
// checked against a queue of expected {data, finish cycle} entries.
module tb_alu_exec_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_TO  = 80;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [3:0]  func_control = '0;
  logic [3:0]  inner_control = '0;
  logic        mem_enable = 1'b0;
  logic [3:0]  func_q, inner_q;
  logic [63:0] alu_result = '0;
  logic        csr_we_gate, div_start;
  logic        div_done = 1'b0;
  logic [63:0] div_result = '0;
  logic        mem_req;
  logic [63:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;
  logic        wb_valid, alu_finish, div_timeout_err;
  logic [63:0] wb_data;

  alu_exec_ctrl #(.MUL_LATENCY(MUL_LAT), .DIV_TIMEOUT(DIV_TO)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .func_control(func_control), .inner_control(inner_control), .mem_enable(mem_enable),
    .func_q(func_q), .inner_q(inner_q), .alu_result(alu_result), .csr_we_gate(csr_we_gate),
    .div_start(div_start), .div_done(div_done), .div_result(div_result), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_data(wb_data), .alu_finish(alu_finish), .div_timeout_err(div_timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  func;
    logic [3:0]  inner;
    logic        memEn;
    logic [63:0] aluRes;
    int          divK;
    logic [63:0] divRes;
    int          memK;
    logic [63:0] rdata;
    logic [63:0] expData;
    int          expLat;
  } vec_t;

  typedef struct {
    logic [63:0] data;
    int          finishAt;
  } sbEntry_t;

  sbEntry_t    sbQ[$];
  vec_t        tbl[14];
  vec_t        v;
  int          checks = 0;
  int          errors = 0;
  int          cycleCnt = 0;
  int          accCount = 0;
  int          lastAccept = 0;
  int          prevAccept = 0;
  logic [63:0] nextExpData = '0;
  int          nextExpLat = -1;
  int          divStartCnt = 0, csrCnt = 0, csrStamp = -1, memReqCnt = 0, memAddrBad = 0;
  logic [63:0] expAddr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Handshakes push the expectation prepared by the stimulus; completions pop it.
  always @(negedge clk) begin : monitor
    sbEntry_t e;
    if (rst && instr_valid && instr_ready) begin
      accCount++;
      prevAccept = lastAccept;
      lastAccept = cycleCnt;
      if (nextExpLat >= 0) sbQ.push_back('{nextExpData, cycleCnt + nextExpLat});
    end
    if (div_start) divStartCnt++;
    if (csr_we_gate) begin
      csrCnt++;
      csrStamp = cycleCnt;
    end
    if (mem_req) begin
      memReqCnt++;
      if (mem_addr !== expAddr) memAddrBad++;
    end
    if (wb_valid || alu_finish) begin
      if (sbQ.size() == 0) begin
        check("finish_with_nothing_pending", 64'(wb_valid | alu_finish), 64'd0);
      end else begin
        e = sbQ.pop_front();
        check("wb_data", wb_data, e.data);
        check("finish_cycle", 64'(cycleCnt), 64'(e.finishAt));
        check("wb_valid_eq_alu_finish", 64'(wb_valid), 64'(alu_finish));
      end
    end
  end

  task automatic waitIdle();
    for (int i = 0; i < 300; i++) begin
      if (sbQ.size() == 0) break;
      @(posedge clk);
    end
    if (sbQ.size() != 0) begin
      check("finish_timeout", 64'(sbQ.size()), 64'd0);
      sbQ.delete();
    end
    #1;
  endtask

  task automatic applyStimulus(input vec_t s);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    divStartCnt = 0; csrCnt = 0; csrStamp = -1; memReqCnt = 0; memAddrBad = 0;
    expAddr       = s.aluRes;
    func_control  = s.func;
    inner_control = s.inner;
    mem_enable    = s.memEn;
    alu_result    = s.aluRes;
    div_result    = s.divRes;
    mem_rdata     = s.rdata;
    nextExpData   = s.expData;
    nextExpLat    = s.expLat;
    instr_valid   = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'(instr_ready), 64'd1);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    if (s.divK > 0) begin
      repeat (s.divK) @(posedge clk);
      #1 div_done = 1'b1;
      @(posedge clk);
      #1 div_done = 1'b0;
    end
    if (s.memK > 0) begin
      repeat (s.memK) @(posedge clk);
      #1 mem_ack = 1'b1;
      @(posedge clk);
      #1 mem_ack = 1'b0;
    end
    waitIdle();
  endtask

  task automatic checkOutput(input vec_t s);
    bit expCsr;
    expCsr = !s.memEn && (s.func == 4'd8);
    check("func_q", 64'(func_q), 64'(s.func));
    check("inner_q", 64'(inner_q), 64'(s.inner));
    check("div_start_pulses", 64'(divStartCnt), 64'((!s.memEn && s.func == 4'd3) ? 1 : 0));
    check("csr_gate_pulses", 64'(csrCnt), 64'(expCsr ? 1 : 0));
    if (expCsr) check("csr_gate_cycle", 64'(csrStamp), 64'(lastAccept + 1));
    check("mem_req_cycles", 64'(memReqCnt), 64'(s.memEn ? s.memK : 0));
    if (s.memEn) check("mem_addr_stable", 64'(memAddrBad), 64'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int startAcc;
    tbl[0]  = '{4'd0,  4'd0,  1'b0, 64'd12,                  0, 64'd0,     0, 64'd0,     64'd12,                  2};
    tbl[1]  = '{4'd1,  4'd2,  1'b0, 64'h1_0000_0000,         0, 64'd0,     0, 64'd0,     64'h1_0000_0000,         2};
    tbl[2]  = '{4'd2,  4'd1,  1'b0, 64'd1,                   0, 64'd0,     0, 64'd0,     64'd1,                   2};
    tbl[3]  = '{4'd4,  4'd3,  1'b0, 64'hDEAD_BEEF_0000_1234, 0, 64'd0,     0, 64'd0,     64'hDEAD_BEEF_0000_1234, 2};
    tbl[4]  = '{4'd5,  4'd0,  1'b0, 64'h30,                  0, 64'd0,     0, 64'd0,     64'h30,                  MUL_LAT + 1};
    tbl[5]  = '{4'd6,  4'd0,  1'b0, 64'h8000_1000,           0, 64'd0,     0, 64'd0,     64'h8000_1000,           2};
    tbl[6]  = '{4'd7,  4'd0,  1'b0, 64'h1234_5000,           0, 64'd0,     0, 64'd0,     64'h1234_5000,           2};
    tbl[7]  = '{4'd8,  4'd1,  1'b0, 64'h55,                  0, 64'd0,     0, 64'd0,     64'h55,                  2};
    tbl[8]  = '{4'd12, 4'd15, 1'b0, 64'hABC,                 0, 64'd0,     0, 64'd0,     64'hABC,                 2};
    tbl[9]  = '{4'd3,  4'd0,  1'b0, 64'h777,                 3, 64'd9,     0, 64'd0,     64'd9,                   5};
    tbl[10] = '{4'd3,  4'd1,  1'b0, 64'h777,                 1, 64'h42,    0, 64'd0,     64'h42,                  3};
    tbl[11] = '{4'd0,  4'd0,  1'b1, 64'h8000_0010,           0, 64'd0,     4, 64'hCAFE,  64'hCAFE,                6};
    tbl[12] = '{4'd3,  4'd0,  1'b1, 64'h100,                 0, 64'hBAD,   1, 64'h5,     64'h5,                   3};
    tbl[13] = '{4'd8,  4'd0,  1'b1, 64'h200,                 0, 64'd0,     2, 64'h7,     64'h7,                   4};

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("reset_instr_ready", 64'(instr_ready), 64'd1);
    check("reset_wb_valid", 64'(wb_valid), 64'd0);
    check("reset_alu_finish", 64'(alu_finish), 64'd0);
    check("reset_func_q", 64'(func_q), 64'd0);
    check("reset_inner_q", 64'(inner_q), 64'd0);
    check("reset_mem_req", 64'(mem_req), 64'd0);
    check("reset_mem_addr", mem_addr, 64'd0);
    check("reset_wb_data", wb_data, 64'd0);
    check("reset_div_start", 64'(div_start), 64'd0);
    check("reset_csr_gate", 64'(csr_we_gate), 64'd0);
    check("reset_div_err", 64'(div_timeout_err), 64'd0);

    for (int i = 0; i < 14; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end
    check("div_err_before_timeout", 64'(div_timeout_err), 64'd0);

    v = '{4'd3, 4'd0, 1'b0, 64'h11, -1, 64'd0, 0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, DIV_TO + 2};
    applyStimulus(v);
    checkOutput(v);
    check("div_err_after_timeout", 64'(div_timeout_err), 64'd1);

    // Stray responses while idle must leave state and writeback data untouched.
    @(posedge clk);
    #1;
    mem_ack = 1'b1; div_done = 1'b1; mem_rdata = 64'hBAD; div_result = 64'hBAD;
    @(posedge clk);
    #1 mem_ack = 1'b0; div_done = 1'b0;
    repeat (2) @(negedge clk);
    check("stray_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    check("stray_mem_req", 64'(mem_req), 64'd0);
    check("stray_ready", 64'(instr_ready), 64'd1);

    v = '{4'd0, 4'd0, 1'b0, 64'h99, 0, 64'd0, 0, 64'd0, 64'h99, 2};
    applyStimulus(v);
    checkOutput(v);
    check("div_err_sticky", 64'(div_timeout_err), 64'd1);

    // instr_valid held high: the second accept waits until after DONE.
    @(posedge clk);
    #1;
    func_control = 4'd0; inner_control = 4'd0; mem_enable = 1'b0; alu_result = 64'd12;
    nextExpData = 64'd12; nextExpLat = 2;
    startAcc = accCount;
    instr_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (accCount >= startAcc + 2) break;
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    waitIdle();
    check("held_valid_accepts", 64'(accCount - startAcc), 64'd2);
    check("held_valid_gap", 64'(lastAccept - prevAccept), 64'd3);

    // Reset while waiting on memory: no finish, request drops next cycle.
    @(posedge clk);
    #1;
    func_control = 4'd0; mem_enable = 1'b1; alu_result = 64'h2000; expAddr = 64'h2000;
    nextExpLat = -1;
    instr_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("wait_mem_req", 64'(mem_req), 64'd1);
    check("wait_mem_addr", mem_addr, 64'h2000);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_mem_req", 64'(mem_req), 64'd0);
    check("abort_ready", 64'(instr_ready), 64'd1);
    check("abort_alu_finish", 64'(alu_finish), 64'd0);
    check("abort_div_err", 64'(div_timeout_err), 64'd0);
    check("abort_mem_addr", mem_addr, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_enable = 1'b0;
    repeat (3) @(negedge clk);

    v = '{4'd2, 4'd4, 1'b0, 64'h5A, 0, 64'd0, 0, 64'd0, 64'h5A, 2};
    applyStimulus(v);
    checkOutput(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
